// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, mul/div results queue in a FIFO.
// Zero-latency write mux; md_ready drops when the FIFO is full; stall_req asks for a bubble on starvation.
module wb_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_we,
    input  logic [4:0]                 wb_wn,
    input  logic [WIDTH-1:0]           wb_wd,
    input  logic                       md_valid,
    output logic                       md_ready,
    input  logic [4:0]                 md_wn,
    input  logic [WIDTH-1:0]           md_wd,
    output logic                       rf_we,
    output logic [4:0]                 rf_wn,
    output logic [WIDTH-1:0]           rf_wd,
    output logic                       stall_req,
    input  logic [4:0]                 rs_q,
    input  logic [4:0]                 rt_q,
    output logic                       rs_pend,
    output logic                       rt_pend,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       r_fifo_wn [DEPTH];
    logic [WIDTH-1:0] r_fifo_wd [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;

    logic          w_pipe_busy;
    logic          w_not_empty;
    logic          w_md_fire;
    logic          w_md_nz;
    logic          w_pop;
    logic          w_write_through;
    logic          w_push;
    logic          w_rs_hit;
    logic          w_rt_hit;
    logic [PW-1:0] w_off;

    assign w_pipe_busy     = wb_we && (wb_wn != 5'd0);
    assign w_not_empty     = (r_count != CW'(0));
    assign md_ready        = reset && (r_count != CW'(DEPTH));
    assign w_md_fire       = md_valid && md_ready;
    assign w_md_nz         = (md_wn != 5'd0);
    assign w_pop           = reset && !w_pipe_busy && w_not_empty;
    assign w_write_through = reset && !w_pipe_busy && !w_not_empty && w_md_fire && w_md_nz;
    assign w_push          = w_md_fire && w_md_nz && !w_write_through;

    assign q_count   = r_count;
    assign stall_req = (r_starve == SW'(STARVE_LIMIT));

    always_comb begin
        rf_we = 1'b0;
        rf_wn = wb_wn;
        rf_wd = wb_wd;
        if (reset) begin
            if (w_pipe_busy) begin
                rf_we = 1'b1;
            end else if (w_not_empty) begin
                rf_we = 1'b1;
                rf_wn = r_fifo_wn[r_rptr];
                rf_wd = r_fifo_wd[r_rptr];
            end else if (w_md_fire && w_md_nz) begin
                rf_we = 1'b1;
                rf_wn = md_wn;
                rf_wd = md_wd;
            end
        end
    end

    // Payload storage needs no reset; validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wn[r_wptr] <= md_wn;
            r_fifo_wd[r_wptr] <= md_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop || !w_not_empty) begin
                r_starve <= '0;
            end else if (w_pipe_busy && (r_starve != SW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        w_off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rptr;
            if (CW'(w_off) < r_count) begin
                if (r_fifo_wn[i] == rs_q) w_rs_hit = 1'b1;
                if (r_fifo_wn[i] == rt_q) w_rt_hit = 1'b1;
            end
        end
    end

    assign rs_pend = (rs_q != 5'd0) && (w_rs_hit || (md_valid && (md_wn == rs_q)));
    assign rt_pend = (rt_q != 5'd0) && (w_rt_hit || (md_valid && (md_wn == rt_q)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-scenario tasks with hand-computed expectations.
module tb_wb_port_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic             wb_we;
    logic [4:0]       wb_wn;
    logic [WIDTH-1:0] wb_wd;
    logic             md_valid;
    logic             md_ready;
    logic [4:0]       md_wn;
    logic [WIDTH-1:0] md_wd;
    logic             rf_we;
    logic [4:0]       rf_wn;
    logic [WIDTH-1:0] rf_wd;
    logic             stall_req;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic             rs_pend;
    logic             rt_pend;
    logic [1:0]       q_count;

    int tests;
    int fails;

    wb_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_wn(wb_wn), .wb_wd(wb_wd),
        .md_valid(md_valid), .md_ready(md_ready), .md_wn(md_wn), .md_wd(md_wd),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_wd(rf_wd),
        .stall_req(stall_req),
        .rs_q(rs_q), .rt_q(rt_q), .rs_pend(rs_pend), .rt_pend(rt_pend),
        .q_count(q_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference queue of pending destinations; flags any pipeline write to a queued register.
    logic [4:0] m_q[$];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
        end else begin
            automatic logic busy = wb_we && (wb_wn != 5'd0);
            automatic logic fire = md_valid && (m_q.size() < DEPTH);
            automatic logic wt   = !busy && (m_q.size() == 0) && fire && (md_wn != 5'd0);
            if (busy) begin
                tests++;
                foreach (m_q[k]) begin
                    if (m_q[k] == wb_wn) begin
                        fails++;
                        $display("FAIL waw: pipeline writes r%0d while queued, required no queued match", wb_wn);
                    end
                end
            end
            if (!busy && m_q.size() != 0) void'(m_q.pop_front());
            if (fire && (md_wn != 5'd0) && !wt) m_q.push_back(md_wn);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_we = 1'b0; wb_wn = 5'd0; wb_wd = '0;
        md_valid = 1'b0; md_wn = 5'd0; md_wd = '0;
        rs_q = 5'd0; rt_q = 5'd0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        #2;
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL rst_qcount: got %0d required 0", q_count); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_rfwe: got %b required 0", rf_we); end
        tests++; if (md_ready !== 1'b0) begin fails++; $display("FAIL rst_mdready: got %b required 0", md_ready); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b required 0", stall_req); end
        tick();
        reset = 1'b1;
        #1;
        wb_we = 1'b1; wb_wn = 5'd1; wb_wd = 32'h1111_0000;
        md_valid = 1'b1; md_wn = 5'd7; md_wd = 32'h7;
        tick();
        md_wn = 5'd9; md_wd = 32'h9;
        tick();
        md_valid = 1'b0;
        tests++; if (q_count !== 2'd2) begin fails++; $display("FAIL rst_fill: got %0d required 2", q_count); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL rst_async_qcount: got %0d required 0", q_count); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_async_rfwe: got %b required 0", rf_we); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_async_stall: got %b required 0", stall_req); end
        set_idle();
        #1;
        reset = 1'b1;
        #1;
        tests++; if (md_ready !== 1'b1) begin fails++; $display("FAIL rst_release_mdready: got %b required 1", md_ready); end
        tick();
    endtask

    task automatic test_write_through();
        set_idle();
        md_valid = 1'b1; md_wn = 5'd5; md_wd = 32'hDEAD_BEEF;
        #1;
        tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL wt_we: got %b required 1", rf_we); end
        tests++; if (rf_wn !== 5'd5) begin fails++; $display("FAIL wt_wn: got %0d required 5", rf_wn); end
        tests++; if (rf_wd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wt_wd: got %h required deadbeef", rf_wd); end
        tick();
        md_valid = 1'b0;
        #1;
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL wt_qcount: got %0d required 0", q_count); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL wt_idle: got %b required 0", rf_we); end
    endtask

    task automatic test_pipe_priority();
        set_idle();
        wb_we = 1'b1; wb_wn = 5'd3; wb_wd = 32'hAAAA_AAAA;
        md_valid = 1'b1; md_wn = 5'd7; md_wd = 32'h7777_7777;
        #1;
        tests++; if (rf_wn !== 5'd3 || rf_wd !== 32'hAAAA_AAAA || rf_we !== 1'b1) begin
            fails++; $display("FAIL prio_pipe: got we=%b wn=%0d wd=%h required we=1 wn=3 wd=aaaaaaaa", rf_we, rf_wn, rf_wd);
        end
        tick();
        tests++; if (q_count !== 2'd1) begin fails++; $display("FAIL prio_queued: got %0d required 1", q_count); end
        wb_we = 1'b0; md_valid = 1'b0;
        #1;
        tests++; if (rf_we !== 1'b1 || rf_wn !== 5'd7 || rf_wd !== 32'h7777_7777) begin
            fails++; $display("FAIL prio_drain: got we=%b wn=%0d wd=%h required we=1 wn=7 wd=77777777", rf_we, rf_wn, rf_wd);
        end
        tick();
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL prio_empty: got %0d required 0", q_count); end
    endtask

    task automatic test_full();
        set_idle();
        wb_we = 1'b1; wb_wn = 5'd2; wb_wd = 32'h2;
        md_valid = 1'b1; md_wn = 5'd7; md_wd = 32'h70;
        tick();
        md_wn = 5'd9; md_wd = 32'h90;
        tick();
        md_wn = 5'd11; md_wd = 32'hB0;
        rs_q = 5'd7; rt_q = 5'd9;
        #1;
        tests++; if (q_count !== 2'd2) begin fails++; $display("FAIL full_qcount: got %0d required 2", q_count); end
        tests++; if (md_ready !== 1'b0) begin fails++; $display("FAIL full_mdready: got %b required 0", md_ready); end
        tests++; if (rs_pend !== 1'b1 || rt_pend !== 1'b1) begin
            fails++; $display("FAIL full_pend: got rs=%b rt=%b required rs=1 rt=1", rs_pend, rt_pend);
        end
        rs_q = 5'd11; rt_q = 5'd12;
        #1;
        tests++; if (rs_pend !== 1'b1 || rt_pend !== 1'b0) begin
            fails++; $display("FAIL full_pend_inflight: got rs=%b rt=%b required rs=1 rt=0", rs_pend, rt_pend);
        end
        tick();
        tests++; if (q_count !== 2'd2) begin fails++; $display("FAIL full_hold: got %0d required 2", q_count); end
        wb_we = 1'b0;
        #1;
        tests++; if (rf_wn !== 5'd7 || rf_wd !== 32'h70) begin fails++; $display("FAIL full_drain0: got wn=%0d wd=%h required wn=7 wd=70", rf_wn, rf_wd); end
        tick();
        #1;
        tests++; if (rf_wn !== 5'd9 || rf_wd !== 32'h90 || md_ready !== 1'b1) begin
            fails++; $display("FAIL full_drain1: got wn=%0d wd=%h rdy=%b required wn=9 wd=90 rdy=1", rf_wn, rf_wd, md_ready);
        end
        tick();
        md_valid = 1'b0;
        tests++; if (q_count !== 2'd1) begin fails++; $display("FAIL full_pushpop: got %0d required 1", q_count); end
        #1;
        tests++; if (rf_wn !== 5'd11 || rf_wd !== 32'hB0) begin fails++; $display("FAIL full_held: got wn=%0d wd=%h required wn=11 wd=b0", rf_wn, rf_wd); end
        tick();
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL full_empty: got %0d required 0", q_count); end
    endtask

    task automatic test_starve();
        set_idle();
        wb_we = 1'b1; wb_wn = 5'd4; wb_wd = 32'h4;
        md_valid = 1'b1; md_wn = 5'd12; md_wd = 32'hC;
        tick();
        md_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL starve_early%0d: got %b required 0", e, stall_req); end
        end
        tick();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL starve_rise: got %b required 1", stall_req); end
        tick();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL starve_hold: got %b required 1", stall_req); end
        wb_we = 1'b0;
        #1;
        tests++; if (rf_wn !== 5'd12 || rf_we !== 1'b1 || stall_req !== 1'b1) begin
            fails++; $display("FAIL starve_drain: got we=%b wn=%0d stall=%b required we=1 wn=12 stall=1", rf_we, rf_wn, stall_req);
        end
        tick();
        tests++; if (stall_req !== 1'b0 || q_count !== 2'd0) begin
            fails++; $display("FAIL starve_clear: got stall=%b q=%0d required stall=0 q=0", stall_req, q_count);
        end
    endtask

    task automatic test_zero_reg();
        set_idle();
        md_valid = 1'b1; md_wn = 5'd0; md_wd = 32'h1234_5678;
        #1;
        tests++; if (md_ready !== 1'b1 || rf_we !== 1'b0 || rs_pend !== 1'b0) begin
            fails++; $display("FAIL zero_idle: got rdy=%b we=%b rs_pend=%b required 1 0 0", md_ready, rf_we, rs_pend);
        end
        tick();
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL zero_dropped: got %0d required 0", q_count); end
        wb_we = 1'b1; wb_wn = 5'd6; wb_wd = 32'h6;
        md_wn = 5'd8; md_wd = 32'h8;
        tick();
        md_wn = 5'd0;
        rt_q = 5'd8;
        #1;
        tests++; if (rt_pend !== 1'b1 || rs_pend !== 1'b0 || rf_wn !== 5'd6) begin
            fails++; $display("FAIL zero_busy: got rt=%b rs=%b wn=%0d required rt=1 rs=0 wn=6", rt_pend, rs_pend, rf_wn);
        end
        tick();
        md_valid = 1'b0;
        tests++; if (q_count !== 2'd1) begin fails++; $display("FAIL zero_unchanged: got %0d required 1", q_count); end
        wb_wn = 5'd0;
        #1;
        tests++; if (rf_we !== 1'b1 || rf_wn !== 5'd8) begin
            fails++; $display("FAIL zero_r0_pipe: got we=%b wn=%0d required we=1 wn=8", rf_we, rf_wn);
        end
        tick();
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL zero_drained: got %0d required 0", q_count); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  wn_tab [3];
        logic [31:0] wd_tab [3];
        wn_tab = '{5'd20, 5'd21, 5'd31};
        wd_tab = '{32'h0000_0014, 32'hFFFF_FFFF, 32'h8000_0001};
        set_idle();
        md_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            md_wn = wn_tab[i]; md_wd = wd_tab[i];
            #1;
            tests++; if (rf_we !== 1'b1 || rf_wn !== wn_tab[i] || rf_wd !== wd_tab[i]) begin
                fails++; $display("FAIL b2b%0d: got we=%b wn=%0d wd=%h required we=1 wn=%0d wd=%h", i, rf_we, rf_wn, rf_wd, wn_tab[i], wd_tab[i]);
            end
            tick();
        end
        md_valid = 1'b0;
        tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL b2b_qcount: got %0d required 0", q_count); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_through();
        test_pipe_priority();
        test_full();
        test_starve();
        test_zero_reg();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the pipeline write-back stage (the MEM/WB register outputs after the MemtoReg mux);
  - a multi-cycle mul/div unit that returns results out of band.
- The pipeline always wins. Mul/div results wait in a small FIFO and drain into idle write-back slots.
- A starvation counter requests a pipeline bubble when the FIFO waits too long.
- A pending-register scoreboard tells the hazard unit when an ID-stage source is still waiting in the FIFO.

Parameters:
- WIDTH, 32, data width of the write-port and mul/div result data.
- DEPTH, 2, mul/div result FIFO entries (power of 2, ≥ 2).
- STARVE_LIMIT, 4, consecutive blocked cycles before stall_req asserts (≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  pipeline write-back RegWrite.
- wb_wn  in  5  pipeline write-back destination register.
- wb_wd  in  WIDTH  pipeline write-back data.
- md_valid  in  1  mul/div result valid.
- md_ready  out  1  arbiter can accept a mul/div result.
- md_wn  in  5  mul/div destination register.
- md_wd  in  WIDTH  mul/div result data.
- rf_we  out  1  register-file write enable.
- rf_wn  out  5  register-file write register.
- rf_wd  out  WIDTH  register-file write data.
- stall_req  out  1  request to the hazard unit: hold the front end and inject a bubble into MEM/WB.
- rs_q  in  5  ID-stage rs query.
- rt_q  in  5  ID-stage rt query.
- rs_pend  out  1  rs has a pending mul/div write.
- rt_pend  out  1  rt has a pending mul/div write.
- q_count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Definitions:
  - pipe_busy = wb_we && (wb_wn != 0).
  - md_fire = md_valid && md_ready.
- Reset (reset == 0, asynchronous): FIFO emptied (pointers = 0, q_count = 0), starve_cnt = 0, stall_req = 0. Any queued results are discarded. While reset is low, rf_we = 0 and md_ready = 0.
- md_ready = (q_count != DEPTH). It is combinational and is 1 immediately after reset release.
- Write-port mux (combinational, zero latency), evaluated in this order:
  1. pipe_busy → rf = {1, wb_wn, wb_wd}.
  2. Else if q_count != 0 → rf = FIFO head. The FIFO pops at the next rising edge.
  3. Else if md_fire && md_wn != 0 → rf = {1, md_wn, md_wd} (write-through). The result is not enqueued.
  4. Else rf_we = 0. rf_wn and rf_wd then hold don't-care values; the bench checks them only when rf_we = 1.
- Enqueue:
  - md_fire with md_wn != 0 is enqueued at the rising edge unless it was taken by write-through.
  - md_fire with md_wn == 0 is accepted and dropped.
- Simultaneous push and pop: q_count stays unchanged. This is legal when full, but md_ready is 0 when full, so a push never coincides with a full FIFO.
- FIFO order is arrival order. Pointers wrap modulo DEPTH.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each edge where q_count != 0 and pipe_busy.
  - It clears to 0 on any edge where a pop occurs or the FIFO is empty.
- stall_req = (starve_cnt == STARVE_LIMIT), decoded from the register.
- The hazard unit responds by bubbling MEM/WB, so wb_we = 0 in a following cycle. The head then drains, starve_cnt clears, and stall_req drops the cycle after the pop edge.
- If wb_we is still 1 while stall_req = 1, the pipeline keeps priority and stall_req stays high.
- Scoreboard:
  - rs_pend = (rs_q != 0) && (rs_q matches any valid FIFO entry, or (md_valid && md_wn == rs_q)).
  - rt_pend is the same for rt_q.
  - It is combinational. An entry draining this cycle still reports pending.
- WAW: the hazard unit stalls on *_pend, so a pipeline write never targets a register held in the FIFO. The bench asserts this never happens; the RTL takes no action on it.

Test Plan:
1. Reset low mid-operation with 2 queued entries → q_count = 0, rf_we = 0, stall_req = 0 asynchronously. After release, md_ready = 1.
2. Idle pipeline (wb_we = 0), FIFO empty, md_valid = 1, md_wn = 5, md_wd = 0xDEADBEEF → same cycle rf_we = 1, rf_wn = 5, rf_wd = 0xDEADBEEF, q_count stays 0.
3. Pipeline write (wb_we = 1, wb_wn = 3) while md result to r7 arrives, then wb_we = 0 → cycle 0: rf_wn = 3, q_count → 1. Cycle 1: rf_wn = 7, q_count → 0.
4. Two md results under continuous wb_we = 1 → q_count = 2, md_ready = 0. A third md_valid is held, not lost. rs_q = 7 / rt_q = 9 matching the queued entries → rs_pend = rt_pend = 1.
5. Queue 1 entry with wb_we = 1 held → stall_req rises after exactly 4 blocked edges. With wb_we dropped the next cycle → pop, then stall_req = 0.
6. md_valid = 1 with md_wn = 0 → md_ready = 1, rf_we = 0, q_count unchanged, rs_pend = 0 for rs_q = 0.
